// File: rtl/key_scan_pkg.sv
// key_scan_pkg: shared types and constants for the 4x8 key matrix scanner.
package key_scan_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 8;

  // Head-of-queue event: press=1 for a key going down, 0 for a release.
  typedef struct packed {
    logic       press;
    logic [4:0] key;
  } key_event_t;

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } scan_state_t;

  // Key index 8*col + row; with 8 rows this is just {col, row}.
  function automatic logic [4:0] key_index(input logic [1:0] col, input logic [2:0] row);
    return {col, row};
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: small event queue with valid/ready output, registered head
// and a sticky overflow flag for events dropped while full.
module key_event_fifo
  import key_scan_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  key_event_t i_data,
  input  logic       i_ready,
  input  logic       i_ov_clear,
  output logic       o_valid,
  output key_event_t o_head,
  output logic       o_overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  key_event_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          r_valid;
  key_event_t    r_head;
  logic          r_overflow;

  logic          w_pop;
  logic          w_full;
  logic          w_wr_en;
  logic          w_drop;
  logic [CW-1:0] w_count_next;
  logic [CW-1:0] w_left;
  logic [AW-1:0] w_rd_next;
  key_event_t    w_head_next;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  assign w_pop        = r_valid & i_ready;
  assign w_full       = (r_count == CW'(DEPTH));
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_wr_en      = i_push & (~w_full | w_pop);
  assign w_drop       = i_push & w_full & ~w_pop;
  assign w_count_next = r_count + CW'(w_wr_en) - CW'(w_pop);
  assign w_left       = r_count - CW'(w_pop);
  assign w_rd_next    = w_pop ? ptr_inc(r_rd) : r_rd;

  // Next head: hold when empty, bypass the pushed event into an emptied queue,
  // otherwise the oldest surviving entry.
  always_comb begin
    w_head_next = r_head;
    if (w_count_next == {CW{1'b0}}) begin
      w_head_next = r_head;
    end else if (w_left == {CW{1'b0}}) begin
      w_head_next = i_data;
    end else begin
      w_head_next = r_mem[w_rd_next];
    end
  end

  // Storage, pointers, registered head/valid and sticky overflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {1'b0, 5'd0};
      end
      r_wr       <= {AW{1'b0}};
      r_rd       <= {AW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_valid    <= 1'b0;
      r_head     <= {1'b0, 5'd0};
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ptr_inc(r_wr);
      end
      r_rd    <= w_rd_next;
      r_count <= w_count_next;
      r_valid <= (w_count_next != {CW{1'b0}});
      r_head  <= w_head_next;
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_ov_clear) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_head     = r_head;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/key_matrix_scan.sv
// key_matrix_scan: strobes a 4x8 active-low key matrix one column at a time,
// samples the sense lines at the last strobed cycle of each slot, debounces
// each key and queues press/release events.
// Build option: define KEY_SCAN_DEBOUNCE_EN to build the per-key debounce
// counters; without it every sample is taken directly (one-scan debounce).
module key_matrix_scan
  import key_scan_pkg::*;
#(
  parameter int SCAN_DIV_LOG2  = 11,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk12MHz,
  input  logic        reset,
  output logic [3:0]  kcol,
  input  logic [7:0]  ksense,
  output logic [31:0] keys,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [4:0]  ev_key,
  output logic        ev_press,
  output logic        ev_overflow,
  input  logic        ov_clear
);

  localparam int CNT_W = SCAN_DIV_LOG2 + 2;
  // First guard-band phase (3/4 of the slot) and the sample phase just before it.
  localparam logic [SCAN_DIV_LOG2-1:0] PH_GUARD  = SCAN_DIV_LOG2'(3 << (SCAN_DIV_LOG2 - 2));
  localparam logic [SCAN_DIV_LOG2-1:0] PH_SAMPLE = SCAN_DIV_LOG2'((3 << (SCAN_DIV_LOG2 - 2)) - 1);

`ifdef KEY_SCAN_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_SCANS - 1);
  logic [DB_W-1:0] r_db_cnt [32];
`endif

  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cnt_next;
  logic [1:0]               w_col;
  logic [SCAN_DIV_LOG2-1:0] w_ph;
  logic [1:0]               w_next_col;
  logic [SCAN_DIV_LOG2-1:0] w_next_ph;
  logic [3:0]               w_kcol_next;
  logic [3:0]               r_kcol;
  logic [7:0]               r_sync1;
  logic [7:0]               r_sync2;
  logic [7:0]               w_s;

  scan_state_t r_state;
  logic [2:0]  r_row;
  logic [1:0]  r_col;
  logic [7:0]  r_sample;
  logic [31:0] r_keys;
  logic        r_push;
  key_event_t  r_push_ev;
  logic [4:0]  w_key;
  logic        w_bit;

  key_event_t  w_head;
  logic        w_fifo_valid;
  logic        w_fifo_ov;

  assign w_cnt_next = r_cnt + CNT_W'(1);
  assign w_col      = r_cnt[CNT_W-1 -: 2];
  assign w_ph       = r_cnt[SCAN_DIV_LOG2-1:0];
  assign w_next_col = w_cnt_next[CNT_W-1 -: 2];
  assign w_next_ph  = w_cnt_next[SCAN_DIV_LOG2-1:0];

  // Free-running slot counter; wraps from column 3 to column 0 with no gap.
  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  // Strobe decode from the next count so the registered strobe lines up with r_cnt.
  always_comb begin
    w_kcol_next = 4'hF;
    if (w_next_ph < PH_GUARD) begin
      w_kcol_next[w_next_col] = 1'b0;
    end else begin
      w_kcol_next = 4'hF;
    end
  end

  // Registered column strobes (all high in reset and in the guard quarter).
  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      r_kcol <= 4'hF;
    end else begin
      r_kcol <= w_kcol_next;
    end
  end

  // Two-flop synchronizer on the asynchronous sense lines.
  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      r_sync1 <= 8'hFF;
      r_sync2 <= 8'hFF;
    end else begin
      r_sync1 <= ksense;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s   = ~r_sync2;
  assign w_key = key_index(r_col, r_row);
  assign w_bit = r_sample[r_row];

  // Scan FSM: latch the column sample, then walk its 8 keys one per cycle,
  // debouncing each and registering a push for every key that flips.
  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_row     <= 3'd0;
      r_col     <= 2'd0;
      r_sample  <= 8'h00;
      r_keys    <= 32'h0;
      r_push    <= 1'b0;
      r_push_ev <= {1'b0, 5'd0};
`ifdef KEY_SCAN_DEBOUNCE_EN
      for (int i = 0; i < 32; i++) begin
        r_db_cnt[i] <= {DB_W{1'b0}};
      end
`endif
    end else begin
      r_push <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ph == PH_SAMPLE) begin
            r_sample <= w_s;
            r_col    <= w_col;
            r_row    <= 3'd0;
            r_state  <= UPDATE;
          end
        end
        UPDATE: begin
`ifdef KEY_SCAN_DEBOUNCE_EN
          if (w_bit == r_keys[w_key]) begin
            r_db_cnt[w_key] <= {DB_W{1'b0}};
          end else if (r_db_cnt[w_key] == DB_LAST) begin
            r_keys[w_key]   <= w_bit;
            r_db_cnt[w_key] <= {DB_W{1'b0}};
            r_push          <= 1'b1;
            r_push_ev.press <= w_bit;
            r_push_ev.key   <= w_key;
          end else begin
            r_db_cnt[w_key] <= r_db_cnt[w_key] + DB_W'(1);
          end
`else
          if (w_bit != r_keys[w_key]) begin
            r_keys[w_key]   <= w_bit;
            r_push          <= 1'b1;
            r_push_ev.press <= w_bit;
            r_push_ev.key   <= w_key;
          end
`endif
          r_row <= r_row + 3'd1;
          if (r_row == 3'd7) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  key_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (clk12MHz),
    .i_rst      (reset),
    .i_push     (r_push),
    .i_data     (r_push_ev),
    .i_ready    (ev_ready),
    .i_ov_clear (ov_clear),
    .o_valid    (w_fifo_valid),
    .o_head     (w_head),
    .o_overflow (w_fifo_ov)
  );

  assign kcol        = r_kcol;
  assign keys        = r_keys;
  assign ev_valid    = w_fifo_valid;
  assign ev_key      = w_head.key;
  assign ev_press    = w_head.press;
  assign ev_overflow = w_fifo_ov;

endmodule

// File: tb/tb_key_matrix_scan.sv
// tb_key_matrix_scan: directed bench for key_matrix_scan with a behavioural
// key matrix (sense row pulled low only while its pressed key's column strobes).
module tb_key_matrix_scan;

`ifdef KEY_SCAN_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 1;
`endif
  localparam int SLOT  = 32;
  localparam int FRAME = 4 * SLOT;

  logic        clk;
  logic        reset;
  logic [3:0]  kcol;
  logic [7:0]  ksense;
  logic [31:0] keys;
  logic        ev_valid;
  logic        ev_ready;
  logic [4:0]  ev_key;
  logic        ev_press;
  logic        ev_overflow;
  logic        ov_clear;

  logic [31:0] pressed;
  logic [5:0]  evq[$];
  int          cyc;
  int          n_chk;
  int          n_err;

  key_matrix_scan #(
    .SCAN_DIV_LOG2  (5),
    .DEBOUNCE_SCANS (4),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk12MHz    (clk),
    .reset       (reset),
    .kcol        (kcol),
    .ksense      (ksense),
    .keys        (keys),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_key      (ev_key),
    .ev_press    (ev_press),
    .ev_overflow (ev_overflow),
    .ov_clear    (ov_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix model.
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      ksense[r] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (pressed[8*c + r] && !kcol[c]) ksense[r] = 1'b0;
      end
    end
  end

  // Cycle count since reset release; equals the DUT slot counter modulo FRAME.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Record every accepted event.
  always @(posedge clk) begin
    if (!reset && ev_valid && ev_ready) evq.push_back({ev_press, ev_key});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic next_frame(output int f);
    f = ((cyc / FRAME) + 1) * FRAME;
    run_to(f);
  endtask

  function automatic logic [31:0] ev_at(input int i);
    if (i < evq.size()) return {26'd0, evq[i]};
    else return 32'hFFFF_FFFF;
  endfunction

  initial begin
    int fb;
    int b;
    int bad;
    logic [3:0] exp_kcol;
    n_chk = 0; n_err = 0;
    pressed = 32'h0; ev_ready = 1'b1; ov_clear = 1'b0;
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_kcol", {28'd0, kcol}, 32'hF);
    check("rst_keys", keys, 32'h0);
    check("rst_valid", {31'd0, ev_valid}, 32'h0);
    check("rst_key", {27'd0, ev_key}, 32'h0);
    check("rst_press", {31'd0, ev_press}, 32'h0);
    check("rst_ovf", {31'd0, ev_overflow}, 32'h0);
    reset = 1'b0;

    // Strobe pattern over two frames: 24 strobed cycles, 8 guard cycles per column.
    bad = 0;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      @(negedge clk);
      exp_kcol = 4'hF;
      if ((cyc % SLOT) < 24) exp_kcol[(cyc / SLOT) % 4] = 1'b0;
      if (i == 1) check("first_strobe", {28'd0, kcol}, 32'hE);
      if (kcol !== exp_kcol) bad++;
    end
    check("strobe_pattern", bad, 0);

    // Clean press and release of key 21 (col 2, row 5).
    next_frame(fb);
    evq.delete();
    pressed[21] = 1'b1;
    b = fb + (DB - 1) * FRAME;
    run_to(b + 93);
    check("press_before_upd", {31'd0, keys[21]}, 32'h0);
    run_to(b + 94);
    check("press_upd_cycle6", {31'd0, keys[21]}, 32'h1);
    run_to(b + 95);
    check("press_valid_rise", {31'd0, ev_valid}, 32'h1);
    run_to(fb + DB * FRAME + 10);
    check("press_ev_count", evq.size(), 1);
    check("press_ev", ev_at(0), {26'd0, 1'b1, 5'd21});
    next_frame(fb);
    evq.delete();
    pressed[21] = 1'b0;
    run_to(fb + DB * FRAME + 10);
    check("release_keys", {31'd0, keys[21]}, 32'h0);
    check("release_ev_count", evq.size(), 1);
    check("release_ev", ev_at(0), {26'd0, 1'b0, 5'd21});

    // Short presses.
    next_frame(fb);
    evq.delete();
`ifdef KEY_SCAN_DEBOUNCE_EN
    pressed[21] = 1'b1;
    run_to(fb + 3 * FRAME);
    pressed[21] = 1'b0;
    run_to(fb + 5 * FRAME);
    check("bounce_no_ev", evq.size(), 0);
    check("bounce_keys", {31'd0, keys[21]}, 32'h0);
    pressed[21] = 1'b1;
    run_to(fb + 8 * FRAME);
    pressed[21] = 1'b0;
    run_to(fb + 10 * FRAME + 10);
    check("bounce_restart_no_ev", evq.size(), 0);
    check("bounce_restart_keys", {31'd0, keys[21]}, 32'h0);
`else
    pressed[21] = 1'b1;
    run_to(fb + FRAME);
    pressed[21] = 1'b0;
    run_to(fb + 2 * FRAME + 10);
    check("glitch_ev_count", evq.size(), 2);
    check("glitch_ev_press", ev_at(0), {26'd0, 1'b1, 5'd21});
    check("glitch_ev_release", ev_at(1), {26'd0, 1'b0, 5'd21});
`endif

    // Column burst: all of col 1 at once.
    next_frame(fb);
    evq.delete();
    pressed[15:8] = 8'hFF;
    run_to(fb + DB * FRAME + 10);
    check("burst_keys", {24'd0, keys[15:8]}, 32'hFF);
    check("burst_ev_count", evq.size(), 8);
    for (int i = 0; i < 8; i++) check("burst_ev", ev_at(i), {26'd0, 1'b1, 5'(8 + i)});
    next_frame(fb);
    evq.delete();
    pressed[15:8] = 8'h00;
    run_to(fb + DB * FRAME + 10);
    check("burst_rel_keys", {24'd0, keys[15:8]}, 32'h0);
    check("burst_rel_count", evq.size(), 8);
    check("burst_rel_last", ev_at(7), {26'd0, 1'b0, 5'd15});

    // Backpressure and overflow: 5 keys of col 3, consumer stalled.
    next_frame(fb);
    evq.delete();
    ev_ready = 1'b0;
    pressed[28:24] = 5'h1F;
    b = fb + (DB - 1) * FRAME;
    run_to(b + 125);
    check("ovf_before_drop", {31'd0, ev_overflow}, 32'h0);
    ov_clear = 1'b1;
    run_to(b + 126);
    ov_clear = 1'b0;
    check("ovf_clear_vs_drop", {31'd0, ev_overflow}, 32'h1);
    check("ovf_keys", {27'd0, keys[28:24]}, 32'h1F);
    for (int i = 0; i < 10; i++) begin
      check("hold_head", {25'd0, ev_valid, ev_press, ev_key}, {25'd0, 1'b1, 1'b1, 5'd24});
      @(negedge clk);
    end
    ov_clear = 1'b1;
    @(negedge clk);
    ov_clear = 1'b0;
    check("ovf_cleared", {31'd0, ev_overflow}, 32'h0);
    ev_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("drain_count", evq.size(), 4);
    for (int i = 0; i < 4; i++) check("drain_ev", ev_at(i), {26'd0, 1'b1, 5'(24 + i)});
    check("drain_valid", {31'd0, ev_valid}, 32'h0);
    next_frame(fb);
    pressed[28:24] = 5'h00;
    run_to(fb + DB * FRAME + 10);
    evq.delete();

    // Asynchronous reset mid-UPDATE with two events queued.
    next_frame(fb);
    ev_ready = 1'b0;
    pressed[2:1] = 2'b11;
    b = fb + (DB - 1) * FRAME;
    run_to(b + 28);
    check("pre_rst_valid", {31'd0, ev_valid}, 32'h1);
    check("pre_rst_keys", {30'd0, keys[2:1]}, 32'h3);
    check("pre_rst_head", {26'd0, ev_press, ev_key}, {26'd0, 1'b1, 5'd1});
    #1 reset = 1'b1;
    #1;
    check("arst_kcol", {28'd0, kcol}, 32'hF);
    check("arst_keys", keys, 32'h0);
    check("arst_valid", {31'd0, ev_valid}, 32'h0);
    check("arst_ovf", {31'd0, ev_overflow}, 32'h0);
    check("arst_head", {26'd0, ev_press, ev_key}, 32'h0);
    repeat (10) @(negedge clk);
    check("arst_hold_kcol", {28'd0, kcol}, 32'hF);
    pressed = 32'h0;
    reset = 1'b0;
    @(negedge clk);
    check("rerun_first_strobe", {28'd0, kcol}, 32'hE);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
